// File: rtl/lif_neuron_integrator.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_integrator
// Brief    : Leaky integrate-and-fire neuron; scans one synapse weight per cycle
//            per timestep and fires a postsynaptic spike on threshold crossing.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_integrator #(
    parameter int N_SYN         = 16,
    parameter int W_WIDTH       = 4,
    parameter int V_WIDTH       = 8,
    parameter int THRESHOLD     = 40,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2,
    parameter int A_WIDTH       = (N_SYN > 1) ? $clog2(N_SYN) : 1,
    parameter int R_WIDTH       = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step,
    input  logic [N_SYN-1:0]   pre_spike,
    output logic [A_WIDTH-1:0] weight_addr,
    input  logic [W_WIDTH-1:0] weight_data,
    output logic               post_spike,
    output logic               done,
    output logic               busy,
    output logic [V_WIDTH-1:0] membrane,
    output logic [7:0]         spike_count
);

    localparam logic [1:0]         c_IDLE      = 2'd0;
    localparam logic [1:0]         c_SCAN      = 2'd1;
    localparam logic [1:0]         c_FIRE      = 2'd2;
    localparam logic [A_WIDTH-1:0] c_LAST_IDX  = A_WIDTH'(N_SYN - 1);
    localparam logic [V_WIDTH:0]   c_THRESHOLD = (V_WIDTH + 1)'(THRESHOLD);
    localparam logic [R_WIDTH-1:0] c_REFRACT   = R_WIDTH'(REFRACT_STEPS);

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    logic [N_SYN-1:0]   r_preQ;
    logic [A_WIDTH-1:0] r_idx;
    logic [R_WIDTH-1:0] r_refractCnt;
    logic               r_skip;
    logic [V_WIDTH-1:0] r_membrane;
    logic [7:0]         r_spikeCount;
    logic               r_postSpike;
    logic               r_done;
    logic [V_WIDTH:0]   w_sum;
    logic [V_WIDTH-1:0] w_sumClamped;

    // One extra bit catches the carry so the accumulation saturates instead of wrapping.
    assign w_sum        = {1'b0, r_membrane} + {{(V_WIDTH + 1 - W_WIDTH){1'b0}}, weight_data};
    assign w_sumClamped = w_sum[V_WIDTH] ? {V_WIDTH{1'b1}} : w_sum[V_WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (step) begin
                    w_nextState = (r_refractCnt == '0) ? c_SCAN : c_FIRE;
                end
            end
            c_SCAN: begin
                if (r_idx == c_LAST_IDX) begin
                    w_nextState = c_FIRE;
                end
            end
            c_FIRE:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != c_IDLE);
        weight_addr = '0;
        if (r_state == c_SCAN) begin
            weight_addr = r_idx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_preQ       <= '0;
            r_idx        <= '0;
            r_refractCnt <= '0;
            r_skip       <= 1'b0;
            r_membrane   <= '0;
            r_spikeCount <= '0;
            r_postSpike  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_postSpike <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (step) begin
                        if (r_refractCnt == '0) begin
                            r_preQ     <= pre_spike;
                            r_membrane <= r_membrane - (r_membrane >> LEAK_SHIFT);
                            r_idx      <= '0;
                            r_skip     <= 1'b0;
                        end else begin
                            r_skip <= 1'b1;
                        end
                    end
                end
                c_SCAN: begin
                    if (r_preQ[r_idx]) begin
                        r_membrane <= w_sumClamped;
                    end
                    r_idx <= r_idx + A_WIDTH'(1);
                end
                c_FIRE: begin
                    r_done <= 1'b1;
                    if (r_skip) begin
                        r_refractCnt <= r_refractCnt - R_WIDTH'(1);
                    end else if ({1'b0, r_membrane} >= c_THRESHOLD) begin
                        r_postSpike  <= 1'b1;
                        r_membrane   <= '0;
                        r_refractCnt <= c_REFRACT;
                        if (r_spikeCount != 8'hFF) begin
                            r_spikeCount <= r_spikeCount + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign post_spike  = r_postSpike;
    assign done        = r_done;
    assign membrane    = r_membrane;
    assign spike_count = r_spikeCount;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron_integrator
// Brief    : Self-checking bench: vector table plus scoreboard for the neuron.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_integrator;

    logic        clock = 1'b0;
    logic        reset;
    logic        step, step2;
    logic [15:0] preSpike, preSpike2;
    logic [3:0]  weightAddr, weightAddr2;
    logic [3:0]  weightData, weightData2;
    logic        postSpike, done, busy;
    logic        postSpike2, done2, busy2;
    logic [7:0]  membrane, spikeCount, membrane2, spikeCount2;
    logic [3:0]  wmem [16];
    logic [3:0]  wmem2 [16];

    always #5 clock = ~clock;

    assign weightData  = wmem[weightAddr];
    assign weightData2 = wmem2[weightAddr2];

    lif_neuron_integrator dut (
        .clock(clock), .reset(reset), .step(step), .pre_spike(preSpike),
        .weight_addr(weightAddr), .weight_data(weightData),
        .post_spike(postSpike), .done(done), .busy(busy),
        .membrane(membrane), .spike_count(spikeCount)
    );

    lif_neuron_integrator #(.THRESHOLD(255)) dut255 (
        .clock(clock), .reset(reset), .step(step2), .pre_spike(preSpike2),
        .weight_addr(weightAddr2), .weight_data(weightData2),
        .post_spike(postSpike2), .done(done2), .busy(busy2),
        .membrane(membrane2), .spike_count(spikeCount2)
    );

    typedef struct {
        logic        ramp;
        logic [3:0]  w;
        logic [15:0] pre;
        int          lat;
        logic        spike;
        logic [7:0]  mem;
        logic [7:0]  cnt;
    } vec_t;

    typedef struct {
        logic       spike;
        logic [7:0] mem;
        logic [7:0] cnt;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[14];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && done === 1'b1) begin
            check("sb_pending_on_done", 32'(sbQ.size() != 0), 1);
            if (sbQ.size() != 0) begin
                exp_t e;
                e = sbQ.pop_front();
                check("sb_post_spike", 32'(postSpike), 32'(e.spike));
                check("sb_membrane", 32'(membrane), 32'(e.mem));
                check("sb_spike_count", 32'(spikeCount), 32'(e.cnt));
                check("sb_busy_low_on_done", 32'(busy), 0);
            end
        end
        if (reset === 1'b1 && postSpike === 1'b1) begin
            check("spike_needs_done", 32'(done), 1);
        end
    end

    task automatic applyVec(input vec_t v, input int n);
        int lat;
        @(negedge clock);
        for (int i = 0; i < 16; i++) wmem[i] = v.ramp ? 4'(i) : v.w;
        preSpike = v.pre;
        sbQ.push_back(exp_t'{v.spike, v.mem, v.cnt});
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        lat  = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check($sformatf("vec%0d_latency", n), 32'(lat), 32'(v.lat));
    endtask

    task automatic runStep2(input int n, output logic [7:0] memAt16);
        int lat;
        memAt16 = '0;
        @(negedge clock);
        step2 = 1'b1;
        @(negedge clock);
        step2 = 1'b0;
        lat   = 0;
        while (done2 !== 1'b1 && lat < 40) begin
            if (lat == 16) memAt16 = membrane2;
            @(negedge clock);
            lat++;
        end
        check($sformatf("t5_step%0d_latency", n), 32'(lat), 17);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m16;
        int lat;
        reset     = 1'b0;
        step      = 1'b0;
        step2     = 1'b0;
        preSpike  = '0;
        preSpike2 = '0;
        for (int i = 0; i < 16; i++) begin
            wmem[i]  = 4'd0;
            wmem2[i] = 4'd15;
        end

        // Expected results hand-derived from leak, sum and threshold rules.
        vecs[0]  = '{1'b0, 4'd5,  16'h007F, 17, 1'b0, 8'd35, 8'd0};
        vecs[1]  = '{1'b0, 4'd5,  16'h0000, 17, 1'b0, 8'd31, 8'd0};
        vecs[2]  = '{1'b1, 4'd0,  16'h8001, 17, 1'b1, 8'd0,  8'd1};
        vecs[3]  = '{1'b0, 4'd5,  16'hFFFF, 1,  1'b0, 8'd0,  8'd1};
        vecs[4]  = '{1'b0, 4'd5,  16'hFFFF, 1,  1'b0, 8'd0,  8'd1};
        vecs[5]  = '{1'b1, 4'd0,  16'h00F0, 17, 1'b0, 8'd22, 8'd1};
        vecs[6]  = '{1'b0, 4'd15, 16'h0003, 17, 1'b1, 8'd0,  8'd2};
        vecs[7]  = '{1'b0, 4'd9,  16'hFFFF, 1,  1'b0, 8'd0,  8'd2};
        vecs[8]  = '{1'b0, 4'd9,  16'hFFFF, 1,  1'b0, 8'd0,  8'd2};
        vecs[9]  = '{1'b0, 4'd9,  16'h0003, 17, 1'b0, 8'd18, 8'd2};
        vecs[10] = '{1'b1, 4'd0,  16'hF000, 17, 1'b1, 8'd0,  8'd3};
        vecs[11] = '{1'b0, 4'd15, 16'hFFFF, 1,  1'b0, 8'd0,  8'd3};
        vecs[12] = '{1'b0, 4'd15, 16'hFFFF, 1,  1'b0, 8'd0,  8'd3};
        vecs[13] = '{1'b0, 4'd15, 16'hFFFF, 17, 1'b1, 8'd0,  8'd4};

        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_post_spike", 32'(postSpike), 0);
        check("rst_membrane", 32'(membrane), 0);
        check("rst_spike_count", 32'(spikeCount), 0);
        check("rst_weight_addr", 32'(weightAddr), 0);
        @(negedge clock);
        reset = 1'b1;

        // Asynchronous reset in the middle of a scan.
        @(negedge clock);
        for (int i = 0; i < 16; i++) wmem[i] = 4'd5;
        preSpike = 16'hFFFF;
        step     = 1'b1;
        @(posedge clock);
        #1 step = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        check("t1_membrane_before", 32'(membrane), 25);
        check("t1_addr_before", 32'(weightAddr), 5);
        check("t1_busy_before", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("t1_busy_after", 32'(busy), 0);
        check("t1_membrane_after", 32'(membrane), 0);
        check("t1_addr_after", 32'(weightAddr), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (25) @(negedge clock);

        for (int n = 0; n < 14; n++) applyVec(vecs[n], n);

        // Steps arriving mid-scan must be dropped.
        doReset();
        @(negedge clock);
        for (int i = 0; i < 16; i++) wmem[i] = 4'd5;
        preSpike = 16'hFFFF;
        sbQ.push_back(exp_t'{1'b1, 8'd0, 8'd1});
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        lat  = 0;
        while (done !== 1'b1 && lat < 40) begin
            step = (lat == 2 || lat == 9);
            @(negedge clock);
            lat++;
        end
        step = 1'b0;
        check("t6_latency", 32'(lat), 17);
        repeat (25) @(negedge clock);
        check("t6_no_extra_done", 32'(sbQ.size()), 0);

        // Saturation across leaked carry-over with a threshold only reachable at full scale.
        preSpike2 = 16'hFFFF;
        runStep2(1, m16);
        check("t5_step1_membrane", 32'(membrane2), 240);
        check("t5_step1_no_spike", 32'(postSpike2), 0);
        runStep2(2, m16);
        check("t5_step2_clamped", 32'(m16), 255);
        check("t5_step2_spike", 32'(postSpike2), 1);
        check("t5_step2_membrane", 32'(membrane2), 0);
        check("t5_step2_count", 32'(spikeCount2), 1);

        repeat (3) @(negedge clock);
        check("sb_drained", 32'(sbQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
